// File: rtl/apu_i2s_out.sv
// APU audio back-end: box-car decimator, one-entry hold register and a
// mono 16-bit I2S serialiser (left/right carry the same word).
module apu_i2s_out #(
    parameter int DECIM_LOG2 = 5,
    parameter int BCLK_HALF  = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cpu_clk_en,
    input  logic [15:0] audio_in,
    input  logic        mute,
    input  logic        clear_overrun,
    output logic        sample_valid,
    output logic        overrun,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);
    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int DIV_W = $clog2(BCLK_HALF);
    localparam logic [DIV_W-1:0]      DIV_TC  = DIV_W'(BCLK_HALF - 1);
    localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

    // decimator
    logic [ACC_W-1:0]      acc_q, acc_d, sum;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [15:0]           avg;
    logic                  dec_wr;

    // hold register and status
    logic [15:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ovr_set;

    // serialiser
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       slot_q, slot_d, slot_nx;
    logic [31:0]      sr_q, sr_d;
    logic             sdata_q, sdata_d;
    logic             lr_q, lr_d;
    logic             div_tc, bclk_fall, frame_load, consume;
    logic [15:0]      load_word;

    assign sum    = acc_q + ACC_W'(audio_in);
    assign avg    = sum[DECIM_LOG2 +: 16];
    assign dec_wr = cpu_clk_en && (cnt_q == CNT_MAX);

    assign div_tc     = (div_q == DIV_TC);
    assign bclk_fall  = div_tc && bclk_q;
    assign slot_nx    = slot_q + 5'd1;
    assign frame_load = bclk_fall && (slot_q == 5'd31);
    // A frame load always drains a pending sample; mute only replaces the word.
    assign consume    = frame_load && hold_full_q;
    assign load_word  = mute        ? 16'h0000 :
                        hold_full_q ? hold_q   : sr_q[31:16];
    assign ovr_set    = dec_wr && hold_full_q && !consume;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (cpu_clk_en) begin
            if (dec_wr) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + DECIM_LOG2'(1);
            end
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        // The write lands after the same-cycle consume has taken the old value.
        if (dec_wr) begin
            hold_d      = avg ^ 16'h8000;
            hold_full_d = 1'b1;
        end else if (consume) begin
            hold_full_d = 1'b0;
        end
        valid_d = dec_wr;
        ovr_d   = ovr_set ? 1'b1 : (clear_overrun ? 1'b0 : ovr_q);
    end

    always_comb begin
        div_d   = div_tc ? '0 : div_q + DIV_W'(1);
        bclk_d  = div_tc ? ~bclk_q : bclk_q;
        slot_d  = slot_q;
        sr_d    = sr_q;
        sdata_d = sdata_q;
        lr_d    = lr_q;
        if (bclk_fall) begin
            slot_d = slot_nx;
            if (frame_load) begin
                sr_d    = {load_word, load_word};
                sdata_d = load_word[15];
            end else begin
                sdata_d = sr_q[5'd31 - slot_nx];
            end
            // Word select leads the data by one bit: high for slots 15..30.
            lr_d = (slot_nx >= 5'd15) && (slot_nx != 5'd31);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= '0;
            sr_q        <= '0;
            sdata_q     <= 1'b0;
            lr_q        <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            sr_q        <= sr_d;
            sdata_q     <= sdata_d;
            lr_q        <= lr_d;
        end
    end

    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lr_q;
    assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_apu_i2s_out.sv
// Directed bench for apu_i2s_out: an I2S receiver decodes each frame and
// compares it against expected words queued when the samples are driven.
module tb_apu_i2s_out;
    logic        clk = 1'b0;
    logic        rst_l;
    logic        cpu_clk_en;
    logic [15:0] audio_in;
    logic        mute;
    logic        clear_overrun;
    logic        sample_valid, overrun, i2s_bclk, i2s_lrclk, i2s_sdata;

    apu_i2s_out #(.DECIM_LOG2(2), .BCLK_HALF(2)) dut (
        .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en), .audio_in(audio_in),
        .mute(mute), .clear_overrun(clear_overrun), .sample_valid(sample_valid),
        .overrun(overrun), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int f, input logic [15:0] w);
        exp_t e;
        e.frame = f;
        e.word  = w;
        sb.push_back(e);
    endtask

    // receiver: samples data on bclk rising, a word ends where lrclk changes
    logic        bclk_prev, lr_prev;
    logic [31:0] win;
    logic [15:0] left_w;
    int          nbits, fcnt, lcnt;

    always @(negedge clk) begin
        if (!rst_l) begin
            bclk_prev = 1'b0;
            lr_prev   = 1'b0;
            win       = '0;
            left_w    = '0;
            nbits     = 0;
            fcnt      = 0;
            lcnt      = 0;
        end else begin
            if (i2s_bclk && !bclk_prev) begin
                win = {win[30:0], i2s_sdata};
                if (i2s_lrclk !== lr_prev) begin
                    chk("word_len", nbits + 1, 16);
                    if (i2s_lrclk) begin
                        left_w = win[15:0];
                        lcnt++;
                    end else begin
                        chk("lr_match", {16'h0, win[15:0]}, {16'h0, left_w});
                        while (sb.size() > 0 && sb[0].frame < fcnt) begin
                            chk("sb_missed", sb[0].frame, fcnt);
                            void'(sb.pop_front());
                        end
                        if (sb.size() > 0 && sb[0].frame == fcnt) begin
                            exp_t e;
                            e = sb.pop_front();
                            chk($sformatf("frame%0d", fcnt), {16'h0, win[15:0]}, {16'h0, e.word});
                        end
                        fcnt++;
                    end
                    nbits = 0;
                end else begin
                    nbits++;
                end
                lr_prev = i2s_lrclk;
            end
            bclk_prev = i2s_bclk;
        end
    end

    task automatic wait_left();
        int  l0;
        bit  ok;
        l0 = lcnt;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lcnt != l0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_left", 32'(ok), 1);
    endtask

    task automatic wait_frame(input int k);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fcnt >= k) begin
                ok = 1;
                break;
            end
        end
        chk("wait_frame", 32'(ok), 1);
    endtask

    task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        logic [15:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            audio_in   = v[i];
            cpu_clk_en = 1'b1;
            @(negedge clk);
            chk("sample_valid", 32'(sample_valid), 32'(i == 3));
        end
        cpu_clk_en = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid",   32'(sample_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_bclk",    32'(i2s_bclk), 0);
        chk("rst_lrclk",   32'(i2s_lrclk), 0);
        chk("rst_sdata",   32'(i2s_sdata), 0);
    endtask

    initial begin
        rst_l = 1'b0; cpu_clk_en = 1'b0; audio_in = '0; mute = 1'b0; clear_overrun = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        push_exp(0, 16'h0000);
        rst_l = 1'b1;

        // constant level: 0x4000 -> 0xC000
        wait_left();
        feed4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        chk("ovr_const", 32'(overrun), 0);
        push_exp(1, 16'hC000);

        // averaging with truncation: 11/4 -> 2
        wait_left();
        feed4(16'd1, 16'd2, 16'd3, 16'd5);
        push_exp(2, 16'h8002);

        // underrun repeats the last loaded word
        wait_left();
        feed4(16'h0010, 16'h0010, 16'h0010, 16'h0010);
        push_exp(3, 16'h8010);
        push_exp(4, 16'h8010);
        push_exp(5, 16'h8010);
        push_exp(6, 16'h8010);
        wait_frame(6);
        chk("ovr_underrun", 32'(overrun), 0);

        // overrun: two samples inside one frame, the second one is sent
        wait_left();
        feed4(16'h1111, 16'h1111, 16'h1111, 16'h1111);
        chk("ovr_first", 32'(overrun), 0);
        feed4(16'h2222, 16'h2222, 16'h2222, 16'h2222);
        chk("ovr_set", 32'(overrun), 1);
        push_exp(7, 16'hA222);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("ovr_clear", 32'(overrun), 0);

        // set and clear in the same cycle: set wins
        wait_left();
        feed4(16'h3333, 16'h3333, 16'h3333, 16'h3333);
        clear_overrun = 1'b1;
        feed4(16'h4444, 16'h4444, 16'h4444, 16'h4444);
        chk("ovr_set_wins", 32'(overrun), 1);
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("ovr_clear2", 32'(overrun), 0);
        push_exp(8, 16'hC444);

        // mute zeroes the frame and drains the pending sample
        wait_left();
        feed4(16'h5555, 16'h5555, 16'h5555, 16'h5555);
        mute = 1'b1;
        push_exp(9, 16'h0000);
        wait_left();
        mute = 1'b0;
        feed4(16'h6666, 16'h6666, 16'h6666, 16'h6666);
        chk("ovr_after_mute", 32'(overrun), 0);
        push_exp(10, 16'hE666);
        wait_frame(11);
        chk("sb_empty_pre_rst", sb.size(), 0);

        // reset in the middle of the right word (slot 20)
        wait_left();
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                if (nbits == 5) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("wait_slot20", 32'(ok), 1);
        end
        rst_l = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        push_exp(0, 16'h0000);
        push_exp(1, 16'h0000);
        rst_l = 1'b1;
        wait_left();
        wait_left();
        feed4(16'h7777, 16'h7777, 16'h7777, 16'h7777);
        push_exp(2, 16'hF777);
        wait_frame(3);
        chk("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
